pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage core.
- Generates the enable and flush controls for the PC register and for the IF/ID, ID/EX and EX/MEM pipeline registers. IF_ID_FLUSH drives the IF/ID register's PC_SEL squash input.
- Resolves, in priority order: data-memory wait, control redirect, load-use hazard, instruction-fetch wait.
- Keeps saturating stall and flush performance counters.

Parameters:
REG_AW, 5, register-address width
FLUSH_CYCLES, 2, cycles IF/ID is squashed per redirect (fetch latency + 1); legal 1..15
CNT_W, 32, performance counter width

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous, active-high reset
ID_RS1  in  REG_AW  source reg 1 of instruction in ID
ID_RS2  in  REG_AW  source reg 2 of instruction in ID
ID_USE_RS1  in  1  ID instruction reads RS1
ID_USE_RS2  in  1  ID instruction reads RS2
EX_RD  in  REG_AW  destination reg of instruction in EX
EX_MEM_READ  in  1  instruction in EX is a load
EX_REDIRECT  in  1  branch taken / jump resolved in EX
IMEM_READY  in  1  fetch data valid this cycle
DMEM_READY  in  1  data access in MEM completes this cycle (1 when MEM idle)
PC_ENA  out  1  PC register load enable
IF_ID_ENA  out  1  IF/ID enable
IF_ID_FLUSH  out  1  IF/ID squash (to PC_SEL)
ID_EX_ENA  out  1  ID/EX enable
ID_EX_FLUSH  out  1  ID/EX bubble insert
EX_MEM_ENA  out  1  EX/MEM enable
STALL_CNT  out  CNT_W  cycles with PC_ENA=0
FLUSH_CNT  out  CNT_W  accepted redirects

Behaviour:
- State machine with three states:
  - RUN.
  - MEM_WAIT.
  - FLUSH, with a 4-bit down-counter fcnt.
- Control outputs are combinational from state and inputs, giving zero-cycle stall response. Counters are registered.
- While RST=1:
  - state=RUN, fcnt=0, STALL_CNT=0, FLUSH_CNT=0.
  - All ENA outputs forced 0; IF_ID_FLUSH=1, ID_EX_FLUSH=1.
  - This holds immediately and asynchronously, including mid-stall and mid-flush.
- Default action (no condition active): all ENA=1, all FLUSH=0.
- Priority 1, DMEM_READY=0 (any state):
  - Outputs: all ENA=0, all FLUSH=0. The pipeline is frozen and EX_REDIRECT is ignored.
  - Transition: next state MEM_WAIT. If entered from FLUSH, fcnt is held.
- MEM_WAIT:
  - While DMEM_READY=0, stay frozen.
  - On DMEM_READY=1, the cycle evaluates as RUN, or as FLUSH if fcnt!=0.
  - A redirect frozen in EX is therefore taken on the first ready cycle.
- Priority 2, EX_REDIRECT=1 and DMEM_READY=1:
  - Outputs: PC_ENA=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1, EX_MEM_ENA=1.
  - FLUSH_CNT increments.
  - If FLUSH_CYCLES>1: fcnt<=FLUSH_CYCLES-1 and next state FLUSH; otherwise RUN.
  - A redirect arriving in FLUSH restarts fcnt.
  - Redirect wins over a simultaneous load-use hazard.
- FLUSH state, no higher-priority event:
  - Outputs: PC_ENA=IMEM_READY, IF_ID_FLUSH=1; ID/EX and EX/MEM advance.
  - fcnt decrements; on fcnt reaching 0, next state RUN.
  - Load-use detection is suppressed, since ID holds a bubble.
- Priority 3, load-use hazard (RUN only):
  - Detection: EX_MEM_READ && EX_RD!=0 && ((ID_USE_RS1 && ID_RS1==EX_RD) || (ID_USE_RS2 && ID_RS2==EX_RD)).
  - Outputs: PC_ENA=0, IF_ID_ENA=0, ID_EX_FLUSH=1, EX_MEM_ENA=1.
  - Exactly one bubble results, because the hazard clears once the load leaves EX.
- Priority 4, IMEM_READY=0 (RUN):
  - Outputs: PC_ENA=0, IF_ID_FLUSH=1; ID/EX and EX/MEM advance.
- ENA/FLUSH interaction: when a FLUSH output is 1, the corresponding ENA output is don't-care and is driven to 1.
- Counters:
  - STALL_CNT increments on every non-reset cycle with PC_ENA=0.
  - Both counters saturate at all-ones; no wrap.

Test Plan:
- Reset: RST=1 mid-FLUSH (fcnt=1) -> same cycle PC_ENA=0, IF_ID_FLUSH=1, ID_EX_FLUSH=1; after RST=0 state RUN, STALL_CNT=0, FLUSH_CNT=0.
- Load-use: EX_MEM_READ=1, EX_RD=5, ID_RS2=5, ID_USE_RS2=1 -> one cycle PC_ENA=0, IF_ID_ENA=0, ID_EX_FLUSH=1. Next cycle (EX_MEM_READ=0) all ENA=1. STALL_CNT +1. Repeat with EX_RD=0 -> no stall.
- Redirect, FLUSH_CYCLES=2: EX_REDIRECT pulse -> cycle 0: IF_ID_FLUSH=1, ID_EX_FLUSH=1, PC_ENA=1; cycle 1: IF_ID_FLUSH=1, ID_EX_FLUSH=0; cycle 2: RUN. FLUSH_CNT=1.
- Simultaneous events: EX_REDIRECT=1 plus load-use hazard -> redirect response only, no IF_ID_ENA=0. Second EX_REDIRECT in FLUSH cycle 1 -> FLUSH_CNT=2, squash extends two further cycles.
- Memory wait: DMEM_READY=0 for 3 cycles while EX_REDIRECT=1 -> 3 cycles all ENA=0, all FLUSH=0, FLUSH_CNT unchanged, STALL_CNT +3. Fourth cycle (ready) -> redirect taken, FLUSH_CNT +1.
- Fetch wait and saturation: IMEM_READY=0 in RUN -> PC_ENA=0, IF_ID_FLUSH=1, ID_EX_ENA=1. With CNT_W=4, 20 stall cycles -> STALL_CNT=15, held.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: combinational pipeline-register
// enables and squashes from a small RUN/MEM_WAIT/FLUSH machine, plus saturating counters.
module pipeline_hazard_ctrl #(
   parameter int REG_AW       = 5,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [REG_AW-1:0] ID_RS1,
   input  logic [REG_AW-1:0] ID_RS2,
   input  logic              ID_USE_RS1,
   input  logic              ID_USE_RS2,
   input  logic [REG_AW-1:0] EX_RD,
   input  logic              EX_MEM_READ,
   input  logic              EX_REDIRECT,
   input  logic              IMEM_READY,
   input  logic              DMEM_READY,
   output logic              PC_ENA,
   output logic              IF_ID_ENA,
   output logic              IF_ID_FLUSH,
   output logic              ID_EX_ENA,
   output logic              ID_EX_FLUSH,
   output logic              EX_MEM_ENA,
   output logic [CNT_W-1:0]  STALL_CNT,
   output logic [CNT_W-1:0]  FLUSH_CNT
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

   localparam logic [3:0]       FCNT_INIT = 4'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t     state, state_nxt;
   logic [3:0] fcnt, fcnt_nxt;
   logic       load_use;
   logic       in_flush;
   logic       redirect_acc;

   assign load_use = EX_MEM_READ && (EX_RD != '0) &&
                     ((ID_USE_RS1 && (ID_RS1 == EX_RD)) ||
                      (ID_USE_RS2 && (ID_RS2 == EX_RD)));

   // MEM_WAIT entered from FLUSH keeps fcnt, so a nonzero count resumes the squash
   assign in_flush = (state != RUN) && (fcnt != 4'd0);

   always_comb begin
      PC_ENA       = 1'b1;
      IF_ID_ENA    = 1'b1;
      IF_ID_FLUSH  = 1'b0;
      ID_EX_ENA    = 1'b1;
      ID_EX_FLUSH  = 1'b0;
      EX_MEM_ENA   = 1'b1;
      state_nxt    = RUN;
      fcnt_nxt     = fcnt;
      redirect_acc = 1'b0;
      if (RST) begin
         PC_ENA      = 1'b0;
         IF_ID_ENA   = 1'b0;
         IF_ID_FLUSH = 1'b1;
         ID_EX_ENA   = 1'b0;
         ID_EX_FLUSH = 1'b1;
         EX_MEM_ENA  = 1'b0;
         fcnt_nxt    = 4'd0;
      end else if (!DMEM_READY) begin
         PC_ENA     = 1'b0;
         IF_ID_ENA  = 1'b0;
         ID_EX_ENA  = 1'b0;
         EX_MEM_ENA = 1'b0;
         state_nxt  = MEM_WAIT;
      end else if (EX_REDIRECT) begin
         IF_ID_FLUSH  = 1'b1;
         ID_EX_FLUSH  = 1'b1;
         redirect_acc = 1'b1;
         fcnt_nxt     = (FLUSH_CYCLES > 1) ? FCNT_INIT : 4'd0;
         state_nxt    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else if (in_flush) begin
         // ID holds a bubble here, so load-use detection is skipped
         PC_ENA      = IMEM_READY;
         IF_ID_FLUSH = 1'b1;
         fcnt_nxt    = fcnt - 4'd1;
         state_nxt   = (fcnt == 4'd1) ? RUN : FLUSH;
      end else if (load_use) begin
         PC_ENA      = 1'b0;
         IF_ID_ENA   = 1'b0;
         ID_EX_FLUSH = 1'b1;
         fcnt_nxt    = 4'd0;
      end else if (!IMEM_READY) begin
         PC_ENA      = 1'b0;
         IF_ID_FLUSH = 1'b1;
         fcnt_nxt    = 4'd0;
      end else begin
         fcnt_nxt = 4'd0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= RUN;
         fcnt      <= 4'd0;
         STALL_CNT <= '0;
         FLUSH_CNT <= '0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
         if (!PC_ENA && (STALL_CNT != '1))
            STALL_CNT <= STALL_CNT + CNT_ONE;
         if (redirect_acc && (FLUSH_CNT != '1))
            FLUSH_CNT <= FLUSH_CNT + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: the driver queues expected controls and
// counters per cycle; the negedge monitor pops and compares against the DUT.
module tb_pipeline_hazard_ctrl;

   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;

   // {PC_ENA, IF_ID_ENA, IF_ID_FLUSH, ID_EX_ENA, ID_EX_FLUSH, EX_MEM_ENA}
   localparam logic [5:0] C_RUN   = 6'b110101;
   localparam logic [5:0] C_LU    = 6'b000111;
   localparam logic [5:0] C_REDIR = 6'b111111;
   localparam logic [5:0] C_FL    = 6'b111101;
   localparam logic [5:0] C_FLNI  = 6'b011101;
   localparam logic [5:0] C_FRZ   = 6'b000000;
   localparam logic [5:0] C_RST   = 6'b001010;

   logic              CLK = 1'b0;
   logic              RST;
   logic [REG_AW-1:0] ID_RS1, ID_RS2, EX_RD;
   logic              ID_USE_RS1, ID_USE_RS2, EX_MEM_READ, EX_REDIRECT;
   logic              IMEM_READY, DMEM_READY;
   logic              PC_ENA, IF_ID_ENA, IF_ID_FLUSH, ID_EX_ENA, ID_EX_FLUSH, EX_MEM_ENA;
   logic [CNT_W-1:0]  STALL_CNT, FLUSH_CNT;

   typedef struct {
      string      tag;
      logic [5:0] ctrl;
      logic [3:0] scnt;
      logic [3:0] fcnt;
   } exp_t;

   exp_t       exp_q[$];
   int         n_chk  = 0;
   int         n_pass = 0;
   logic [3:0] m_scnt = 4'd0;
   logic [3:0] m_fcnt = 4'd0;

   pipeline_hazard_ctrl #(.REG_AW(REG_AW), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST),
      .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2),
      .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ), .EX_REDIRECT(EX_REDIRECT),
      .IMEM_READY(IMEM_READY), .DMEM_READY(DMEM_READY),
      .PC_ENA(PC_ENA), .IF_ID_ENA(IF_ID_ENA), .IF_ID_FLUSH(IF_ID_FLUSH),
      .ID_EX_ENA(ID_EX_ENA), .ID_EX_FLUSH(ID_EX_FLUSH), .EX_MEM_ENA(EX_MEM_ENA),
      .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
   );

   always #5 CLK = ~CLK;

   function automatic logic [5:0] ctrl_now();
      return {PC_ENA, IF_ID_ENA, IF_ID_FLUSH, ID_EX_ENA, ID_EX_FLUSH, EX_MEM_ENA};
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_idle();
      ID_RS1 = '0; ID_RS2 = '0; ID_USE_RS1 = 1'b0; ID_USE_RS2 = 1'b0;
      EX_RD = '0; EX_MEM_READ = 1'b0; EX_REDIRECT = 1'b0;
      IMEM_READY = 1'b1; DMEM_READY = 1'b1;
   endtask

   // Called just after a rising edge: drive one cycle, queue its expectation, advance.
   task automatic drive(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd, input logic mr,
                        input logic redir, input logic imr, input logic dmr,
                        input logic [5:0] ectrl, input logic redir_taken);
      exp_t e;
      ID_RS1 = rs1; ID_RS2 = rs2; ID_USE_RS1 = u1; ID_USE_RS2 = u2;
      EX_RD = rd; EX_MEM_READ = mr; EX_REDIRECT = redir;
      IMEM_READY = imr; DMEM_READY = dmr;
      e.tag = tag; e.ctrl = ectrl; e.scnt = m_scnt; e.fcnt = m_fcnt;
      exp_q.push_back(e);
      if (!ectrl[5] && m_scnt != 4'hF) m_scnt = m_scnt + 4'd1;
      if (redir_taken && m_fcnt != 4'hF) m_fcnt = m_fcnt + 4'd1;
      @(posedge CLK); #1;
   endtask

   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check_val({e.tag, "_ctrl"}, 32'(ctrl_now()), 32'(e.ctrl));
         check_val({e.tag, "_scnt"}, 32'(STALL_CNT), 32'(e.scnt));
         check_val({e.tag, "_fcnt"}, 32'(FLUSH_CNT), 32'(e.fcnt));
      end
   end

   initial begin
      RST = 1'b1;
      set_idle();
      repeat (2) @(posedge CLK);
      #1;
      check_val("rst_ctrl", 32'(ctrl_now()), 32'(C_RST));
      check_val("rst_scnt", 32'(STALL_CNT), 32'd0);
      RST = 1'b0;

      drive("idle",      0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0);
      drive("lu_rs2",    0, 5, 0, 1, 5, 1, 0, 1, 1, C_LU, 0);
      drive("lu_after",  0, 5, 0, 1, 5, 0, 0, 1, 1, C_RUN, 0);
      drive("lu_rs1",    7, 0, 1, 0, 7, 1, 0, 1, 1, C_LU, 0);
      drive("lu_rd0",    0, 0, 0, 1, 0, 1, 0, 1, 1, C_RUN, 0);
      drive("lu_nouse",  0, 9, 1, 0, 9, 1, 0, 1, 1, C_RUN, 0);

      drive("redir0",    0, 0, 0, 0, 0, 0, 1, 1, 1, C_REDIR, 1);
      drive("redir1",    0, 0, 0, 0, 0, 0, 0, 1, 1, C_FL, 0);
      drive("redir2",    0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0);

      drive("sim_lu",    0, 3, 0, 1, 3, 1, 1, 1, 1, C_REDIR, 1);
      drive("re_redir",  0, 0, 0, 0, 0, 0, 1, 1, 1, C_REDIR, 1);
      drive("fl_nolu",   0, 4, 0, 1, 4, 1, 0, 1, 1, C_FL, 0);
      drive("fl_end",    0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0);

      drive("redir_ni",  0, 0, 0, 0, 0, 0, 1, 1, 1, C_REDIR, 1);
      drive("fl_imem",   0, 0, 0, 0, 0, 0, 0, 0, 1, C_FLNI, 0);
      drive("fl_ni_end", 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0);

      for (int i = 0; i < 3; i++)
         drive("mw_frz",  0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 0);
      drive("mw_take",   0, 0, 0, 0, 0, 0, 1, 1, 1, C_REDIR, 1);
      drive("mw_fl",     0, 0, 0, 0, 0, 0, 0, 1, 1, C_FL, 0);
      drive("mw_run",    0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0);

      drive("mf_redir",  0, 0, 0, 0, 0, 0, 1, 1, 1, C_REDIR, 1);
      drive("mf_frz",    0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 0);
      drive("mf_resume", 0, 0, 0, 0, 0, 0, 0, 1, 1, C_FL, 0);
      drive("mf_run",    0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0);

      drive("fetchw",    0, 0, 0, 0, 0, 0, 0, 0, 1, C_FLNI, 0);

      // asynchronous reset in the middle of a flush
      drive("ar_redir",  0, 0, 0, 0, 0, 0, 1, 1, 1, C_REDIR, 1);
      set_idle();
      #1;
      check_val("ar_preflush", 32'(ctrl_now()), 32'(C_FL));
      RST = 1'b1;
      #1;
      check_val("ar_ctrl", 32'(ctrl_now()), 32'(C_RST));
      check_val("ar_scnt", 32'(STALL_CNT), 32'd0);
      check_val("ar_fcnt", 32'(FLUSH_CNT), 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      m_scnt = 4'd0;
      m_fcnt = 4'd0;
      drive("ar_run",    0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0);

      for (int i = 0; i < 20; i++)
         drive("sat",     0, 0, 0, 0, 0, 0, 0, 0, 1, C_FLNI, 0);
      drive("sat_hold",  0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0);
      drive("sat_hold2", 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0);

      check_val("q_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
